// File: rtl/frame_buffer_scheduler.sv
// Ring of NUM_BUFS DRAM frame buffers shared by one writer and one reader; newest completed frame wins.
// Latency: grants and state changes visible one cycle after the request; requests held as levels until granted.
module frame_buffer_scheduler #(
    parameter int          NUM_BUFS   = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0F80_0000,
    parameter logic [31:0] BUF_STRIDE = 32'h0040_0000
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic                    wr_req,
    output logic                    wr_grant,
    output logic                    wr_active,
    output logic [31:0]             wr_base,
    input  logic                    wr_done,
    input  logic                    wr_abort,
    input  logic                    rd_req,
    output logic                    rd_grant,
    output logic                    rd_active,
    output logic [31:0]             rd_base,
    output logic                    rd_fresh,
    input  logic                    rd_done,
    output logic [15:0]             drop_count,
    output logic [3*NUM_BUFS-1:0]   buf_state,
    output logic                    err
);

    localparam int IW = $clog2(NUM_BUFS);

    localparam logic [2:0] S_FREE    = 3'd0;
    localparam logic [2:0] S_WRITING = 3'd1;
    localparam logic [2:0] S_READY   = 3'd2;
    localparam logic [2:0] S_READING = 3'd3;
    localparam logic [2:0] S_SHOWN   = 3'd4;

    logic [2:0]    st_q [NUM_BUFS];
    logic [2:0]    st_d [NUM_BUFS];
    logic [IW-1:0] wr_idx_q;

    logic          ready_vld, shown_vld, free_vld;
    logic [IW-1:0] ready_idx, shown_idx, writing_idx, reading_idx, free_idx;
    logic          wr_start, wr_fin_done, wr_fin_abort;
    logic          rd_start_fresh, rd_start_rep, rd_fin, drop, proto_err;

    function automatic logic [31:0] base_of(input logic [IW-1:0] idx);
        return BASE_ADDR + BUF_STRIDE * {{(32-IW){1'b0}}, idx};
    endfunction

    // Classify the registered buffer states; each class holds at most one buffer.
    always_comb begin
        ready_vld   = 1'b0;
        shown_vld   = 1'b0;
        ready_idx   = '0;
        shown_idx   = '0;
        writing_idx = '0;
        reading_idx = '0;
        for (int i = 0; i < NUM_BUFS; i++) begin
            if (st_q[i] == S_READY) begin
                ready_vld = 1'b1;
                ready_idx = IW'(i);
            end
            if (st_q[i] == S_SHOWN) begin
                shown_vld = 1'b1;
                shown_idx = IW'(i);
            end
            if (st_q[i] == S_WRITING) writing_idx = IW'(i);
            if (st_q[i] == S_READING) reading_idx = IW'(i);
        end
    end

    // Round-robin search for a FREE buffer starting just after the last writer buffer.
    always_comb begin
        int k;
        k        = 0;
        free_vld = 1'b0;
        free_idx = '0;
        for (int j = 1; j <= NUM_BUFS; j++) begin
            k = (int'(wr_idx_q) + j) % NUM_BUFS;
            if (!free_vld && st_q[k] == S_FREE) begin
                free_vld = 1'b1;
                free_idx = IW'(k);
            end
        end
    end

    always_comb begin
        wr_start       = wr_req && !wr_active && free_vld;
        wr_fin_abort   = wr_abort && wr_active;
        wr_fin_done    = wr_done && !wr_abort && wr_active;
        rd_start_fresh = rd_req && !rd_active && ready_vld;
        rd_start_rep   = rd_req && !rd_active && !ready_vld && shown_vld;
        rd_fin         = rd_done && rd_active;
        // An old READY frame handed to the reader this cycle is not a drop.
        drop           = wr_fin_done && ready_vld && !rd_start_fresh;
        proto_err      = ((wr_done || wr_abort) && !wr_active) || (rd_done && !rd_active);
    end

    // Next buffer states; every transition below touches a distinct buffer.
    always_comb begin
        for (int i = 0; i < NUM_BUFS; i++) st_d[i] = st_q[i];
        if (rd_start_fresh) begin
            st_d[ready_idx] = S_READING;
            if (shown_vld) st_d[shown_idx] = S_FREE;
        end
        if (rd_start_rep) st_d[shown_idx]   = S_READING;
        if (rd_fin)       st_d[reading_idx] = S_SHOWN;
        if (drop)         st_d[ready_idx]   = S_FREE;
        if (wr_fin_abort) st_d[writing_idx] = S_FREE;
        if (wr_fin_done)  st_d[writing_idx] = S_READY;
        if (wr_start)     st_d[free_idx]    = S_WRITING;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < NUM_BUFS; i++) st_q[i] <= S_FREE;
            wr_idx_q   <= IW'(NUM_BUFS - 1);
            wr_grant   <= 1'b0;
            wr_active  <= 1'b0;
            wr_base    <= '0;
            rd_grant   <= 1'b0;
            rd_active  <= 1'b0;
            rd_base    <= '0;
            rd_fresh   <= 1'b0;
            drop_count <= '0;
            err        <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BUFS; i++) st_q[i] <= st_d[i];
            wr_grant <= wr_start;
            rd_grant <= rd_start_fresh || rd_start_rep;
            rd_fresh <= rd_start_fresh;
            if (wr_start) begin
                wr_idx_q  <= free_idx;
                wr_active <= 1'b1;
                wr_base   <= base_of(free_idx);
            end else if (wr_fin_abort || wr_fin_done) begin
                wr_active <= 1'b0;
            end
            if (rd_start_fresh) begin
                rd_active <= 1'b1;
                rd_base   <= base_of(ready_idx);
            end else if (rd_start_rep) begin
                rd_active <= 1'b1;
                rd_base   <= base_of(shown_idx);
            end else if (rd_fin) begin
                rd_active <= 1'b0;
            end
            if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            if (proto_err) err <= 1'b1;
        end
    end

    always_comb begin
        buf_state = '0;
        for (int i = 0; i < NUM_BUFS; i++) buf_state[3*i +: 3] = st_q[i];
    end

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Directed bench: grant responses checked through expected-value queues, state checked after each step.
module tb_frame_buffer_scheduler;

    localparam logic [31:0] B0 = 32'h0F80_0000;
    localparam logic [31:0] B1 = 32'h0FC0_0000;
    localparam logic [31:0] B2 = 32'h1000_0000;
    localparam logic [31:0] B3 = 32'h1040_0000;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        wr_req, wr_done, wr_abort, rd_req, rd_done;
    logic        wr_grant, wr_active, rd_grant, rd_active, rd_fresh, err;
    logic [31:0] wr_base, rd_base;
    logic [15:0] drop_count;
    logic [11:0] buf_state;

    int vecs = 0;
    int errs = 0;
    logic [31:0] wr_q [$];
    logic [32:0] rd_q [$];

    frame_buffer_scheduler dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .wr_req     (wr_req),
        .wr_grant   (wr_grant),
        .wr_active  (wr_active),
        .wr_base    (wr_base),
        .wr_done    (wr_done),
        .wr_abort   (wr_abort),
        .rd_req     (rd_req),
        .rd_grant   (rd_grant),
        .rd_active  (rd_active),
        .rd_base    (rd_base),
        .rd_fresh   (rd_fresh),
        .rd_done    (rd_done),
        .drop_count (drop_count),
        .buf_state  (buf_state),
        .err        (err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        tick();
        sys_rst_n = 1'b1;
    endtask

    task automatic wr_grab(input logic [31:0] exp_base);
        wr_q.push_back(exp_base);
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        tick();
    endtask

    task automatic rd_grab(input logic [31:0] exp_base, input logic exp_fresh);
        rd_q.push_back({exp_fresh, exp_base});
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
    endtask

    task automatic pulse_wr_done();
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
    endtask

    task automatic pulse_rd_done();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
    endtask

    initial begin
        logic [31:0] ew;
        logic [32:0] er;
        sys_rst_n = 1'b0;
        {wr_req, wr_done, wr_abort, rd_req, rd_done} = '0;

        // Grant monitor: every grant pulse must match the oldest queued expectation.
        fork
            forever begin
                @(negedge sys_clk);
                if (wr_grant) begin
                    if (wr_q.size() == 0) begin
                        vecs++; errs++;
                        $display("FAIL wr_grant: got unexpected grant base %h expected none", wr_base);
                    end else begin
                        ew = wr_q.pop_front();
                        chk("wr_base", wr_base, ew);
                    end
                end
                if (rd_grant) begin
                    if (rd_q.size() == 0) begin
                        vecs++; errs++;
                        $display("FAIL rd_grant: got unexpected grant base %h expected none", rd_base);
                    end else begin
                        er = rd_q.pop_front();
                        chk("rd_base", rd_base, er[31:0]);
                        chk("rd_fresh", {31'd0, rd_fresh}, {31'd0, er[32]});
                    end
                end
            end
        join_none

        tick(); tick();
        sys_rst_n = 1'b1;
        chk("rst_buf_state", {20'd0, buf_state}, 32'h0);
        chk("rst_active", {30'd0, wr_active, rd_active}, 32'h0);
        chk("rst_bases", wr_base | rd_base, 32'h0);
        chk("rst_drop_err", {15'd0, err, drop_count}, 32'h0);

        // First writer grant lands on buffer 0
        wr_grab(B0);
        chk("t1_buf0", {29'd0, buf_state[2:0]}, 32'd1);
        chk("t1_wr_active", {31'd0, wr_active}, 32'd1);

        pulse_wr_done();
        chk("t2_done_state", {20'd0, buf_state}, 32'h002);
        chk("t2_wr_active", {31'd0, wr_active}, 32'd0);
        wr_grab(B1);
        chk("t2_state_w1", {20'd0, buf_state}, 32'h00A);
        rd_grab(B0, 1'b1);
        chk("t2_buf0_reading", {29'd0, buf_state[2:0]}, 32'd3);
        chk("t2_rd_active", {31'd0, rd_active}, 32'd1);

        // Unread frame superseded
        do_reset();
        wr_grab(B0);
        pulse_wr_done();
        wr_grab(B1);
        pulse_wr_done();
        chk("t3_state", {20'd0, buf_state}, 32'h010);
        chk("t3_drop", {16'd0, drop_count}, 32'd1);
        rd_grab(B1, 1'b1);
        chk("t3_state_rd", {20'd0, buf_state}, 32'h018);

        // Repeat of last frame
        pulse_rd_done();
        chk("t4_shown", {20'd0, buf_state}, 32'h020);
        chk("t4_rd_base_hold", rd_base, B1);
        rd_grab(B1, 1'b0);
        chk("t4_repeat_state", {20'd0, buf_state}, 32'h018);
        pulse_rd_done();

        // Nothing written: reader request must stay pending without a grant
        do_reset();
        rd_req = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        rd_req = 1'b0;
        tick();
        chk("t4_no_grant_active", {31'd0, rd_active}, 32'd0);
        chk("t4_no_grant_state", {20'd0, buf_state}, 32'h0);

        // Reader takes old READY frame in the same cycle the writer completes
        do_reset();
        wr_grab(B0);
        pulse_wr_done();
        rd_grab(B0, 1'b1);
        wr_grab(B1);
        pulse_wr_done();
        wr_grab(B2);
        chk("t5_setup", {20'd0, buf_state}, 32'h053);
        pulse_rd_done();
        chk("t5_shown", {20'd0, buf_state}, 32'h054);
        rd_q.push_back({1'b1, B1});
        rd_req  = 1'b1;
        wr_done = 1'b1;
        tick();
        rd_req  = 1'b0;
        wr_done = 1'b0;
        tick();
        chk("t5_race_state", {20'd0, buf_state}, 32'h098);
        chk("t5_race_drop", {16'd0, drop_count}, 32'd0);

        // done + abort together: abort wins
        wr_grab(B3);
        chk("t5_w3", {20'd0, buf_state}, 32'h298);
        wr_done  = 1'b1;
        wr_abort = 1'b1;
        tick();
        wr_done  = 1'b0;
        wr_abort = 1'b0;
        chk("t5_abort_state", {20'd0, buf_state}, 32'h098);
        chk("t5_abort_active", {31'd0, wr_active}, 32'd0);
        chk("t5_abort_drop_err", {15'd0, err, drop_count}, 32'd0);
        chk("t5_wr_base_hold", wr_base, B3);

        pulse_rd_done();
        chk("t5_rd_done_state", {20'd0, buf_state}, 32'h0A0);
        chk("t5_err_clear", {31'd0, err}, 32'd0);
        pulse_rd_done();
        chk("t5_err_set", {31'd0, err}, 32'd1);
        chk("t5_err_state", {20'd0, buf_state}, 32'h0A0);

        // Simultaneous grants, then reset mid-operation
        wr_q.push_back(B0);
        rd_q.push_back({1'b1, B2});
        wr_req = 1'b1;
        rd_req = 1'b1;
        tick();
        wr_req = 1'b0;
        rd_req = 1'b0;
        tick();
        chk("t6_both_state", {20'd0, buf_state}, 32'h0C1);
        chk("t6_both_active", {30'd0, wr_active, rd_active}, 32'h3);
        do_reset();
        chk("t6_rst_state", {20'd0, buf_state}, 32'h0);
        chk("t6_rst_active", {30'd0, wr_active, rd_active}, 32'h0);
        chk("t6_rst_drop_err", {15'd0, err, drop_count}, 32'h0);
        wr_grab(B0);
        chk("t6_after_rst_active", {31'd0, wr_active}, 32'd1);

        tick(); tick();
        while (wr_q.size() != 0) begin
            vecs++; errs++;
            ew = wr_q.pop_front();
            $display("FAIL wr_grant_missing: got no grant expected base %h", ew);
        end
        while (rd_q.size() != 0) begin
            vecs++; errs++;
            er = rd_q.pop_front();
            $display("FAIL rd_grant_missing: got no grant expected base %h", er[31:0]);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/frame_buffer_scheduler.md
Name: frame_buffer_scheduler

Overview:
- Arbitrates a ring of NUM_BUFS frame buffers in DRAM between one writer (sensor capture path feeding the address generator) and one reader (readout/output path).
- Hands each side the base address of its buffer and tracks per-buffer ownership, so a buffer is never written while it is being read.
- Frames the reader never consumed are dropped and counted. The latest completed frame always wins.

Parameters:
- NUM_BUFS, 4, number of buffers; legal range 3..8.
- BASE_ADDR, 32'h0F80_0000, base address of buffer 0.
- BUF_STRIDE, 32'h0040_0000, address distance between consecutive buffers.

Ports:
- sys_clk  in  1  single clock.
- sys_rst_n  in  1  reset, synchronous, active-low.
- wr_req  in  1  writer requests a buffer (level).
- wr_grant  out  1  one-cycle pulse: buffer assigned.
- wr_active  out  1  writer owns a buffer.
- wr_base  out  32  base address of the writer's buffer.
- wr_done  in  1  pulse: frame completely written.
- wr_abort  in  1  pulse: frame discarded.
- rd_req  in  1  reader requests a frame (level).
- rd_grant  out  1  one-cycle pulse: frame assigned.
- rd_active  out  1  reader owns a buffer.
- rd_base  out  32  base address of the reader's buffer.
- rd_fresh  out  1  valid with rd_grant: 1 = new frame, 0 = repeat of the last frame.
- rd_done  in  1  pulse: reader finished the frame.
- drop_count  out  16  count of superseded READY frames; saturates at 16'hFFFF.
- buf_state  out  3*NUM_BUFS  per-buffer state; buffer i occupies bits [3i+2:3i].
- err  out  1  sticky protocol error.

Behaviour:
- Buffer states: FREE=0, WRITING=1, READY=2, READING=3, SHOWN=4. At most one buffer each in WRITING, READY, and READING/SHOWN, so a FREE buffer always exists.
- All decisions in cycle k use the registered state of cycle k; results are visible at k+1.
- base(i) = BASE_ADDR + i*BUF_STRIDE, computed modulo 2^32.

Reset (sys_rst_n low at a clock edge), which aborts any operation in progress:
- All buffers FREE; all outputs 0, including wr_base, rd_base, drop_count and err.
- Writer round-robin pointer wr_idx = NUM_BUFS-1.

Writer:
- wr_req at cycle k with wr_active=0: search for a FREE buffer starting at (wr_idx+1) mod NUM_BUFS, ascending with wrap. Pick the first hit.
- At k+1: that buffer is WRITING, wr_idx = its index, wr_grant=1 for one cycle, wr_active=1, wr_base = its base.
- wr_req while wr_active=1 is ignored (not an error). The writer deasserts wr_req on seeing wr_grant.
- wr_done with wr_active=1: the WRITING buffer becomes READY and wr_active drops to 0. Any previously READY buffer becomes FREE and drop_count increments, unless the reader is granted that old buffer in the same cycle (then no drop).
- wr_abort with wr_active=1: the WRITING buffer becomes FREE, wr_active=0, drop_count unchanged. If wr_done and wr_abort arrive in the same cycle, abort wins.
- wr_base holds its last value after completion or abort.

Reader:
- rd_req at k with rd_active=0 and a READY buffer present: READY becomes READING, and any SHOWN buffer becomes FREE. At k+1: rd_grant=1, rd_fresh=1, rd_active=1, rd_base = that buffer's base.
- If no READY buffer but a SHOWN buffer exists: SHOWN becomes READING; grant as above with rd_fresh=0.
- If neither exists: no grant. The request stays pending while rd_req remains high.
- rd_done with rd_active=1: READING becomes SHOWN, rd_active=0. rd_base holds its value.
- rd_req while rd_active=1 is ignored.

Errors and output timing:
- err is set by wr_done or wr_abort while wr_active=0, or by rd_done while rd_active=0. The offending pulse is otherwise ignored. err clears only on reset.
- wr_grant, rd_grant and rd_fresh are registered outputs.
- Writer and reader may be granted in the same cycle.

Test Plan:
1. Release reset, wr_req at cycle 1 -> wr_grant at cycle 2, wr_base=0x0F80_0000, buf_state[2:0]=1.
2. wr_done, then wr_req -> wr_base=0x0FC0_0000. Then rd_req -> rd_grant, rd_base=0x0F80_0000, rd_fresh=1, buf0=READING.
3. Write frames into buf0 and buf1 with no reader activity -> buf0 FREE, drop_count=1. rd_req -> rd_base=0x0FC0_0000, rd_fresh=1.
4. Reader rd_done, then rd_req again with no new frame -> rd_grant, rd_base unchanged, rd_fresh=0. With no frame ever written, rd_req held 10 cycles -> no rd_grant.
5. Start with buf1 READY. In cycle k, rd_req high and wr_done for buf2 -> reader gets 0x0FC0_0000, buf2 READY, drop_count unchanged. Separately, wr_done and wr_abort in the same cycle -> buffer FREE, wr_active=0. rd_done while idle -> err=1.
6. sys_rst_n low for one cycle while both sides are active -> next cycle all buf_state=0, wr_active=rd_active=0, drop_count=0, err=0. Next wr_req -> wr_base=0x0F80_0000.
